// File: rtl/fp_pkg.sv
// fp_pkg: shared constants and state encoding for the binary32 pack stage.
//   EXP_W/FRAC_W : field widths of the packed word
//   BIAS/EXP_MAX : exponent bias and the reserved all-ones exponent
//   QNAN         : canonical quiet NaN emitted for any NaN input
package fp_pkg;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
endpackage

// File: rtl/fp_round_rne.sv
// fp_round_rne: combinational round-to-nearest-even on a normalised mantissa.
//   man     : [26] overflow, [25] hidden, [24:2] fraction, [1] guard, [0] sticky
//   exp     : signed biased exponent before rounding
//   frac    : rounded 23-bit fraction
//   exp_out : exponent after any rounding renormalisation
//   carry   : rounding increment overflowed the 23-bit fraction
//   inexact : guard or sticky was set
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [26:0]        man,
  input  logic signed [9:0]  exp,
  output logic [FRAC_W-1:0]  frac,
  output logic signed [9:0]  exp_out,
  output logic               carry,
  output logic               inexact
);
  logic inc;

  always_comb begin
    inc     = man[1] & (man[0] | man[2]);
    frac    = man[24:2] + {{(FRAC_W-1){1'b0}}, inc};
    carry   = inc & (&man[24:2]);
    // With the hidden bit set, a fraction carry means 10.000..; shift right
    // (fraction already wraps to zero) and bump the exponent. With the hidden
    // bit clear the carry simply becomes the new hidden bit.
    exp_out = exp + {9'd0, carry & (man[26] | man[25])};
    inexact = man[1] | man[0];
  end
endmodule

// File: rtl/fp_pack.sv
// fp_pack: normalise, round (RNE) and pack a sign/exponent/mantissa result
// into an IEEE-754 binary32 word. One operation in flight, valid/ready on
// both sides.
//   clk, rst                       : clock, async active-high reset
//   in_valid/in_ready              : input handshake (ready only in IDLE)
//   in_sign, in_exp, in_man        : unnormalised result (exp signed, biased)
//   in_zero, in_inf, in_nan        : special-value flags (nan > inf > zero)
//   out_valid/out_ready            : output handshake
//   out_word                       : packed binary32 result
//   out_ovf, out_unf, out_inexact  : status flags, valid with out_valid
// Build option: define FP_PACK_DENORM_EN to produce subnormal results instead
// of flushing tiny results to zero.
module fp_pack
  import fp_pkg::*;
#(
  parameter int unsigned MAX_SHIFT = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [26:0] in_man,
  input  logic        in_zero,
  input  logic        in_inf,
  input  logic        in_nan,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_ovf,
  output logic        out_unf,
  output logic        out_inexact
);
  localparam int unsigned SH_W = $clog2(MAX_SHIFT + 1);
  localparam logic [SH_W-1:0] SH_MAX = SH_W'(MAX_SHIFT);

  state_t             state, state_nx;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [26:0]        man_q, man_d, man_shr;
  logic [SH_W-1:0]    shifts_q, shifts_d;
  logic               zero_q, zero_d;
  logic [31:0]        word_q, word_d;
  logic               ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;

  logic [FRAC_W-1:0]  r_frac;
  logic signed [9:0]  r_exp;
  logic               r_carry, r_inexact, hid_post;

  fp_round_rne u_round (
    .man     (man_q),
    .exp     (exp_q),
    .frac    (r_frac),
    .exp_out (r_exp),
    .carry   (r_carry),
    .inexact (r_inexact)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      man_q    <= '0;
      shifts_q <= '0;
      zero_q   <= 1'b0;
      word_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      man_q    <= man_d;
      shifts_q <= shifts_d;
      zero_q   <= zero_d;
      word_q   <= word_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inx_q    <= inx_d;
    end
  end

  always_comb begin
    state_nx = state;
    sign_d   = sign_q;
    exp_d    = exp_q;
    man_d    = man_q;
    shifts_d = shifts_q;
    zero_d   = zero_q;
    word_d   = word_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    inx_d    = inx_q;
    // Right shift by one with the dropped bit folded into sticky.
    man_shr  = {1'b0, man_q[26:2], man_q[1] | man_q[0]};
    hid_post = man_q[25] | r_carry;

    case (state)
      IDLE: begin
        if (in_valid) begin
          sign_d   = in_sign;
          exp_d    = $signed(in_exp);
          man_d    = in_man;
          shifts_d = '0;
          zero_d   = 1'b0;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          inx_d    = 1'b0;
          state_nx = DONE;
          if (in_nan)       word_d = QNAN;
          else if (in_inf)  word_d = {in_sign, 8'hFF, 23'd0};
          else if (in_zero) word_d = {in_sign, 31'd0};
          else              state_nx = NORM;
        end
      end
      NORM: begin
        if (man_q == '0) begin
          zero_d   = 1'b1;
          state_nx = ROUND;
        end else if (man_q[26]) begin
          man_d = man_shr;
          exp_d = exp_q + 10'sd1;
`ifdef FP_PACK_DENORM_EN
        end else if (exp_q < 10'sd1) begin
          man_d = man_shr;
          exp_d = exp_q + 10'sd1;
`endif
        end else if (!man_q[25] && exp_q > 10'sd1 && shifts_q < SH_MAX) begin
          man_d    = {man_q[25:0], 1'b0};
          exp_d    = exp_q - 10'sd1;
          shifts_d = shifts_q + SH_W'(1);
        end else begin
          state_nx = ROUND;
        end
      end
      ROUND: begin
        state_nx = DONE;
        if (zero_q) begin
          word_d = {sign_q, 31'd0};
        end else if (r_exp >= 10'sd255) begin
          word_d = {sign_q, 8'hFF, 23'd0};
          ovf_d  = 1'b1;
          inx_d  = 1'b1;
`ifdef FP_PACK_DENORM_EN
        end else if (!hid_post) begin
          word_d = {sign_q, 8'h00, r_frac};
          unf_d  = r_inexact;
          inx_d  = r_inexact;
`else
        end else if (exp_q < 10'sd1 || !hid_post) begin
          word_d = {sign_q, 31'd0};
          unf_d  = 1'b1;
          inx_d  = 1'b1;
`endif
        end else begin
          word_d = {sign_q, r_exp[7:0], r_frac};
          inx_d  = r_inexact;
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign out_word    = word_q;
  assign out_ovf     = ovf_q;
  assign out_unf     = unf_q;
  assign out_inexact = inx_q;
endmodule
